// File: rtl/hid_pkg.sv
// hid_pkg: event kinds, report types, scan states and the queued event record.
package hid_pkg;
  typedef enum logic [2:0] {
    EV_NONE       = 3'd0,
    EV_KEY_DOWN   = 3'd1,
    EV_KEY_UP     = 3'd2,
    EV_KEY_REPEAT = 3'd3,
    EV_MOUSE_BTN  = 3'd4,
    EV_GAME_BTN   = 3'd5
  } ev_kind_e;
  typedef enum logic [1:0] {TYP_NONE, TYP_KBD, TYP_MOUSE, TYP_GAME} typ_e;
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN_DN, ST_SCAN_UP} scan_e;
  localparam logic [7:0] KEY_ERR_ROLLOVER = 8'h01;
  localparam int EV_W = 19;
  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] code;
    logic [7:0] aux;
  } ev_t;
endpackage

// File: rtl/hid_ev_fifo.sv
// hid_ev_fifo: first-word-fall-through event queue; head reads as zero while empty.
module hid_ev_fifo
  import hid_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = EV_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic pop, wr_en;
  assign valid_o = cnt_q != '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign pop     = valid_o && ready_i;
  assign wr_en   = push_i && (!full_o || pop);
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_en ? wr_q + AW'(1) : wr_q;
      rd_q  <= pop ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
endmodule

// File: rtl/hid_event_tracker.sv
// hid_event_tracker: turns HID host reports into queued key/mouse/gamepad events
// and keeps a saturating absolute mouse position.
module hid_event_tracker
  import hid_pkg::*;
#(
  parameter int NKEYS        = 4,
  parameter int POS_W        = 10,
  parameter int POS_MAX      = 1023,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_DELAY = 6000000,
  parameter int REPEAT_RATE  = 360000
) (
  input  logic               usbclk,
  input  logic               usbrst,
  input  logic               report,
  input  logic [1:0]         typ,
  input  logic [7:0]         key_modifiers,
  input  logic [8*NKEYS-1:0] keys,
  input  logic [7:0]         mouse_btn,
  input  logic signed [7:0]  mouse_dx,
  input  logic signed [7:0]  mouse_dy,
  input  logic [9:0]         game_btns,
  output logic               ev_valid,
  input  logic               ev_ready,
  output logic [2:0]         ev_kind,
  output logic [7:0]         ev_code,
  output logic [7:0]         ev_aux,
  output logic [POS_W-1:0]   mouse_x,
  output logic [POS_W-1:0]   mouse_y,
  output logic               busy,
  output logic               ev_overflow,
  output logic [7:0]         drop_cnt
);
  localparam int IW = $clog2(NKEYS);
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1);
  localparam logic [POS_W-1:0] PMAX = POS_W'(POS_MAX);
  scan_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NKEYS-1:0][7:0] snap_q, snap_d, prev_q, prev_d;
  logic [7:0] mods_q, mods_d, rep_key_q, rep_key_d, mbtn_q, mbtn_d, drop_cnt_q;
  logic [9:0] gbtn_q, gbtn_d;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic rep_on_q, rep_on_d, ev_overflow_q;
  logic [POS_W-1:0] mx_q, mx_d, my_q, my_d;
  logic rollover, in_prev, in_snap, last, kbd_ok, other_rep, rep_drop, rep_fire;
  logic push, full, ev_drop;
  logic [8:0] drop_sum;
  ev_t push_ev, head;
  function automatic logic [POS_W-1:0] step(input logic [POS_W-1:0] p, input logic [7:0] d);
    logic signed [POS_W+1:0] s;
    s = $signed({2'b00, p}) + $signed({{(POS_W-6){d[7]}}, d});
    return s[POS_W+1] ? '0 : s > $signed({2'b00, PMAX}) ? PMAX : s[POS_W-1:0];
  endfunction
  assign busy      = state_q != ST_IDLE;
  assign last      = idx_q == IW'(NKEYS-1);
  assign rep_drop  = report && busy;
  assign kbd_ok    = report && !busy && typ == TYP_KBD && !rollover;
  assign other_rep = report && !busy && typ != TYP_KBD;
  // A non-keyboard report cancels repeat in the same cycle it would have fired.
  assign rep_fire  = rep_on_q && rep_cnt_q == '0 && !busy && !other_rep;
  always_comb begin
    rollover = 1'b0;
    in_prev  = 1'b0;
    in_snap  = 1'b0;
    for (int j = 0; j < NKEYS; j++) begin
      rollover = rollover | (keys[8*j+:8] == KEY_ERR_ROLLOVER);
      in_prev  = in_prev | (prev_q[j] == snap_q[idx_q]);
      in_snap  = in_snap | (snap_q[j] == prev_q[idx_q]);
    end
  end
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    prev_d    = prev_q;
    mods_d    = mods_q;
    rep_on_d  = rep_on_q;
    rep_key_d = rep_key_q;
    rep_cnt_d = rep_on_q && rep_cnt_q != '0 ? rep_cnt_q - CW'(1) : rep_cnt_q;
    mbtn_d    = mbtn_q;
    gbtn_d    = gbtn_q;
    mx_d      = mx_q;
    my_d      = my_q;
    push      = 1'b0;
    push_ev   = '0;
    if (rep_fire) begin
      push      = 1'b1;
      push_ev   = '{EV_KEY_REPEAT, rep_key_q, mods_q};
      rep_cnt_d = CW'(REPEAT_RATE - 1);
    end
    case (state_q)
      ST_SCAN_DN: begin
        if (snap_q[idx_q] != '0 && !in_prev) begin
          push      = 1'b1;
          push_ev   = '{EV_KEY_DOWN, snap_q[idx_q], mods_q};
          rep_on_d  = 1'b1;
          rep_key_d = snap_q[idx_q];
          rep_cnt_d = CW'(REPEAT_DELAY - 1);
        end
        idx_d   = last ? '0 : idx_q + IW'(1);
        state_d = last ? ST_SCAN_UP : ST_SCAN_DN;
      end
      ST_SCAN_UP: begin
        if (prev_q[idx_q] != '0 && !in_snap) begin
          push     = 1'b1;
          push_ev  = '{EV_KEY_UP, prev_q[idx_q], mods_q};
          rep_on_d = rep_on_q && prev_q[idx_q] != rep_key_q;
        end
        idx_d   = last ? '0 : idx_q + IW'(1);
        state_d = last ? ST_IDLE : ST_SCAN_UP;
        prev_d  = last ? snap_q : prev_q;
      end
      default: begin
        if (kbd_ok) begin
          snap_d  = keys;
          mods_d  = key_modifiers;
          idx_d   = '0;
          state_d = ST_SCAN_DN;
        end
        if (other_rep) begin
          prev_d   = '0;
          rep_on_d = 1'b0;
        end
        if (other_rep && typ == TYP_MOUSE) begin
          mx_d    = step(mx_q, mouse_dx);
          my_d    = step(my_q, mouse_dy);
          mbtn_d  = mouse_btn;
          push    = mouse_btn != mbtn_q;
          push_ev = '{EV_MOUSE_BTN, mouse_btn, 8'h00};
        end
        if (other_rep && typ == TYP_GAME) begin
          gbtn_d  = game_btns;
          push    = game_btns != gbtn_q;
          push_ev = '{EV_GAME_BTN, game_btns[7:0], {6'b0, game_btns[9:8]}};
        end
      end
    endcase
  end
  assign ev_drop  = push && full && !(ev_valid && ev_ready);
  assign drop_sum = {1'b0, drop_cnt_q} + 9'(rep_drop) + 9'(ev_drop);
  always_ff @(posedge usbclk) begin
    if (usbrst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      snap_q        <= '0;
      prev_q        <= '0;
      mods_q        <= '0;
      rep_on_q      <= 1'b0;
      rep_key_q     <= '0;
      rep_cnt_q     <= '0;
      mbtn_q        <= '0;
      gbtn_q        <= '0;
      mx_q          <= PMAX >> 1;
      my_q          <= PMAX >> 1;
      ev_overflow_q <= 1'b0;
      drop_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      prev_q        <= prev_d;
      mods_q        <= mods_d;
      rep_on_q      <= rep_on_d;
      rep_key_q     <= rep_key_d;
      rep_cnt_q     <= rep_cnt_d;
      mbtn_q        <= mbtn_d;
      gbtn_q        <= gbtn_d;
      mx_q          <= mx_d;
      my_q          <= my_d;
      ev_overflow_q <= ev_overflow_q | ev_drop;
      drop_cnt_q    <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end
  hid_ev_fifo #(.DEPTH(FIFO_DEPTH), .W(EV_W)) u_fifo (
    .clk    (usbclk),
    .rst    (usbrst),
    .push_i (push),
    .data_i (push_ev),
    .valid_o(ev_valid),
    .ready_i(ev_ready),
    .data_o (head),
    .full_o (full)
  );
  assign ev_kind     = head.kind;
  assign ev_code     = head.code;
  assign ev_aux      = head.aux;
  assign mouse_x     = mx_q;
  assign mouse_y     = my_q;
  assign ev_overflow = ev_overflow_q;
  assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_hid_event_tracker.sv
// tb_hid_event_tracker: directed reports with hand-computed expected events and positions.
module tb_hid_event_tracker;
  logic clk = 1'b0, usbrst = 1'b1, report = 1'b0, ev_ready = 1'b1;
  logic [1:0] typ = '0;
  logic [7:0] key_modifiers = '0, mouse_btn = '0;
  logic [31:0] keys = '0;
  logic signed [7:0] mouse_dx = '0, mouse_dy = '0;
  logic [9:0] game_btns = '0;
  logic ev_valid, busy, ev_overflow;
  logic [2:0] ev_kind;
  logic [7:0] ev_code, ev_aux, drop_cnt;
  logic [9:0] mouse_x, mouse_y;
  int errors = 0, checks = 0, cyc = 0;
  typedef struct {
    logic [2:0] kind;
    logic [7:0] code;
    logic [7:0] aux;
    int t;
  } rec_t;
  rec_t log_q[$];
  hid_event_tracker #(.NKEYS(4), .POS_W(10), .POS_MAX(1023), .FIFO_DEPTH(8),
                      .REPEAT_DELAY(20), .REPEAT_RATE(5)) dut (
    .usbclk(clk), .usbrst(usbrst), .report(report), .typ(typ),
    .key_modifiers(key_modifiers), .keys(keys), .mouse_btn(mouse_btn),
    .mouse_dx(mouse_dx), .mouse_dy(mouse_dy), .game_btns(game_btns),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_kind(ev_kind), .ev_code(ev_code),
    .ev_aux(ev_aux), .mouse_x(mouse_x), .mouse_y(mouse_y), .busy(busy),
    .ev_overflow(ev_overflow), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    rec_t r;
    if (!usbrst && ev_valid && ev_ready) begin
      r.kind = ev_kind;
      r.code = ev_code;
      r.aux  = ev_aux;
      r.t    = cyc;
      log_q.push_back(r);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic expect_ev(input string tag, input logic [2:0] k, input logic [7:0] c,
                           input logic [7:0] a, output int t);
    rec_t r;
    int n = 0;
    t = -1;
    while (log_q.size() == 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checks++;
    assert (log_q.size() != 0) else begin
      errors++;
      $error("FAIL %s: got no event expected kind=%0d code=%0h aux=%0h", tag, k, c, a);
    end
    if (log_q.size() != 0) begin
      r = log_q.pop_front();
      t = r.t;
      check(tag, {13'b0, r.kind, r.code, r.aux}, {13'b0, k, c, a});
    end
  endtask
  task automatic kbd(input logic [7:0] m, input logic [31:0] k, input int w);
    @(posedge clk); #1;
    report = 1'b1; typ = 2'd1; key_modifiers = m; keys = k;
    @(posedge clk); #1;
    report = 1'b0;
    repeat (w) @(posedge clk);
    #1;
  endtask
  task automatic mouse(input logic [7:0] b, input logic [7:0] dx, input logic [7:0] dy);
    @(posedge clk); #1;
    report = 1'b1; typ = 2'd2; mouse_btn = b; mouse_dx = dx; mouse_dy = dy;
    @(posedge clk); #1;
    report = 1'b0;
  endtask
  task automatic game(input logic [9:0] v);
    @(posedge clk); #1;
    report = 1'b1; typ = 2'd3; game_btns = v;
    @(posedge clk); #1;
    report = 1'b0;
  endtask
  initial begin
    int t0, t1, t2, t3;
    repeat (3) @(posedge clk);
    #1 usbrst = 1'b0;
    check("rst_valid", ev_valid, 0);
    check("rst_head", {ev_kind, ev_code, ev_aux}, 0);
    check("rst_mouse_x", mouse_x, 511);
    check("rst_mouse_y", mouse_y, 511);
    check("rst_busy", busy, 0);
    check("rst_overflow", ev_overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    kbd(8'h02, 32'h00000004, 0);
    check("busy_in_scan", busy, 1);
    repeat (10) @(posedge clk);
    #1 check("busy_after_scan", busy, 0);
    expect_ev("down_04", 3'd1, 8'h04, 8'h02, t0);
    check("no_extra_1", log_q.size(), 0);
    kbd(8'h02, 32'h00000504, 10);
    expect_ev("down_05", 3'd1, 8'h05, 8'h02, t0);
    check("held_04_silent", log_q.size(), 0);
    kbd(8'h00, 32'h00000000, 10);
    expect_ev("up_04", 3'd2, 8'h04, 8'h00, t0);
    expect_ev("up_05", 3'd2, 8'h05, 8'h00, t0);
    repeat (40) @(posedge clk);
    check("repeat_cancelled", log_q.size(), 0);
    kbd(8'h00, 32'h00000005, 10);
    expect_ev("down_05b", 3'd1, 8'h05, 8'h00, t0);
    expect_ev("rep_1", 3'd3, 8'h05, 8'h00, t1);
    expect_ev("rep_2", 3'd3, 8'h05, 8'h00, t2);
    expect_ev("rep_3", 3'd3, 8'h05, 8'h00, t3);
    check("rep_delay", t1 - t0, 20);
    check("rep_rate_1", t2 - t1, 5);
    check("rep_rate_2", t3 - t2, 5);
    kbd(8'h00, 32'h00000000, 10);
    expect_ev("up_05b", 3'd2, 8'h05, 8'h00, t0);
    repeat (40) @(posedge clk);
    check("no_rep_after_up", log_q.size(), 0);
    kbd(8'h00, 32'h00000004, 10);
    expect_ev("down_04b", 3'd1, 8'h04, 8'h00, t0);
    kbd(8'h00, 32'h01010101, 2);
    check("rollover_not_busy", busy, 0);
    check("rollover_silent", log_q.size(), 0);
    kbd(8'h00, 32'h00000000, 10);
    expect_ev("up_04_after_rollover", 3'd2, 8'h04, 8'h00, t0);
    repeat (30) @(posedge clk);
    check("no_extra_2", log_q.size(), 0);
    for (int i = 0; i < 4; i++) mouse(8'h00, 8'h7F, 8'h80);
    check("mouse_x_1019", mouse_x, 1019);
    check("mouse_y_clamp0", mouse_y, 0);
    mouse(8'h00, 8'h7F, 8'h80);
    check("mouse_x_clamp1023", mouse_x, 1023);
    for (int i = 0; i < 7; i++) mouse(8'h00, 8'h80, 8'h00);
    check("mouse_x_127", mouse_x, 127);
    for (int i = 0; i < 3; i++) mouse(8'h00, 8'h80, 8'h00);
    check("mouse_x_clamp0", mouse_x, 0);
    check("mouse_no_btn_ev", log_q.size(), 0);
    mouse(8'h01, 8'h00, 8'h00);
    expect_ev("mouse_btn_01", 3'd4, 8'h01, 8'h00, t0);
    check("mouse_x_hold", mouse_x, 0);
    @(posedge clk); #1 ev_ready = 1'b0;
    for (int i = 1; i <= 10; i++) game({2'(i & 3), 8'(i)});
    @(posedge clk); #1;
    check("fifo_valid_full", ev_valid, 1);
    check("overflow_sticky", ev_overflow, 1);
    check("drop_cnt_2", drop_cnt, 2);
    check("head_first", {ev_kind, ev_code, ev_aux}, {3'd5, 8'h01, 8'h01});
    repeat (5) @(posedge clk);
    #1 check("head_stable", {ev_kind, ev_code, ev_aux}, {3'd5, 8'h01, 8'h01});
    ev_ready = 1'b1;
    for (int i = 1; i <= 8; i++) expect_ev($sformatf("game_%0d", i), 3'd5, 8'(i), 8'(i & 3), t0);
    repeat (5) @(posedge clk);
    #1 check("fifo_drained", ev_valid, 0);
    check("no_dropped_games", log_q.size(), 0);
    kbd(8'h00, 32'h00000004, 0);
    report = 1'b1; typ = 2'd1; keys = 32'h00000006;
    @(posedge clk); #1 report = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("drop_cnt_busy", drop_cnt, 3);
    expect_ev("down_04c", 3'd1, 8'h04, 8'h00, t0);
    check("busy_report_ignored", log_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
